// File: rtl/fuzz_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// fuzz_seq_pkg
// Shared definitions for the fuzz stimulus sequencer: the LCG constants, the
// LCG step function and the controller state type.
// ----------------------------------------------------------------------------
package fuzz_seq_pkg;

   localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
   localparam logic [31:0] LCG_INC = 32'h0000_3039;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRST = 2'd1,
      ST_FILL = 2'd2,
      ST_DONE = 2'd3
   } seq_state_e;

   // One LCG step: cur * MUL + INC, truncated to 32 bits.
   function automatic logic [31:0] lcg_next(input logic [31:0] cur);
      return cur * LCG_MUL + LCG_INC;
   endfunction

endpackage

// File: rtl/fuzz_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// fuzz_seq_ctrl_if
// Control/stimulus bundle between a host (master) and the sequencer (slave).
//   start, seed, cycles, stall      : host -> sequencer
//   dut_rst_n, stim, stim_valid,
//   vec_cnt, busy, done             : sequencer -> host
// ----------------------------------------------------------------------------
interface fuzz_seq_ctrl_if #(
   parameter int IN_W = 258
) ();
   import fuzz_seq_pkg::*;

   logic            start;
   logic [31:0]     seed;
   logic [31:0]     cycles;
   logic            stall;
   logic            dut_rst_n;
   logic [IN_W-1:0] stim;
   logic            stim_valid;
   logic [31:0]     vec_cnt;
   logic            busy;
   logic            done;

   modport master (
      output start, seed, cycles, stall,
      input  dut_rst_n, stim, stim_valid, vec_cnt, busy, done
   );

   modport slave (
      input  start, seed, cycles, stall,
      output dut_rst_n, stim, stim_valid, vec_cnt, busy, done
   );

endinterface

// File: rtl/fuzz_seq_ctrl_lcg32.sv
// ----------------------------------------------------------------------------
// fuzz_lcg32
// 32-bit linear congruential generator.
//   clk   : clock
//   rst   : synchronous active-high reset (state -> 0)
//   load  : load state with seed (has priority over step)
//   seed  : value to load
//   step  : advance the state by one LCG step
//   value : the word the next step produces, i.e. lcg_next(state). The caller
//           consumes this word on the same cycle it asserts step, so the
//           first word after loading seed S is lcg_next(S).
// ----------------------------------------------------------------------------
module fuzz_lcg32
   import fuzz_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] seed,
   input  logic        step,
   output logic [31:0] value
);

   logic [31:0] state_r;

   // LCG state register: reset, load, step or hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= 32'h0000_0000;
      end else if (load) begin
         state_r <= seed;
      end else if (step) begin
         state_r <= lcg_next(state_r);
      end else begin
         state_r <= state_r;
      end
   end

   assign value = lcg_next(state_r);

endmodule

// File: rtl/fuzz_seq_ctrl.sv
// ----------------------------------------------------------------------------
// fuzz_seq_ctrl
// Sequencer that resets a DUT and then feeds it cycles+1 pseudo-random
// stimulus vectors of IN_W bits, one vector every ceil(IN_W/32) cycles.
//   clk  : clock, rst : synchronous active-high reset
//   bus  : fuzz_seq_ctrl_if.slave (start/seed/cycles/stall in;
//          dut_rst_n/stim/stim_valid/vec_cnt/busy/done out)
// Parameters:
//   IN_W        : stimulus width
//   DUT_RST_CYC : cycles dut_rst_n is held low per run (must be >= 1)
// ----------------------------------------------------------------------------
module fuzz_seq_ctrl
   import fuzz_seq_pkg::*;
#(
   parameter int IN_W        = 258,
   parameter int DUT_RST_CYC = 2
) (
   input logic          clk,
   input logic          rst,
   fuzz_seq_ctrl_if.slave bus
);

   localparam int NW    = (IN_W + 31) / 32;
   localparam int SH_W  = NW * 32;
   localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NW - 1);
   localparam logic [31:0]      DRST_LAST = 32'(DUT_RST_CYC - 1);

   seq_state_e       state_r;
   logic [31:0]      drst_cnt_r;
   logic [IDX_W-1:0] widx_r;
   logic [SH_W-1:0]  shadow_r;
   logic [31:0]      cycles_r;
   logic [31:0]      vec_cnt_r;
   logic [IN_W-1:0]  stim_r;
   logic             stim_valid_r;
   logic             dut_rst_n_r;
   logic             busy_r;
   logic             done_r;

   logic             lcg_load_s;
   logic             lcg_step_s;
   logic [31:0]      lcg_word_s;
   logic [SH_W-1:0]  full_s;
   logic [31:0]      vec_cnt_inc_s;
   logic             unused_s;

   fuzz_lcg32 u_lcg (
      .clk   (clk),
      .rst   (rst),
      .load  (lcg_load_s),
      .seed  (bus.seed),
      .step  (lcg_step_s),
      .value (lcg_word_s)
   );

   // LCG control: load on an accepted start, step on every unstalled FILL cycle.
   always_comb begin
      lcg_load_s = 1'b0;
      lcg_step_s = 1'b0;
      if (!bus.stall && bus.start && (state_r == ST_IDLE || state_r == ST_DONE)) begin
         lcg_load_s = 1'b1;
      end else begin
         lcg_load_s = 1'b0;
      end
      if (!bus.stall && state_r == ST_FILL) begin
         lcg_step_s = 1'b1;
      end else begin
         lcg_step_s = 1'b0;
      end
   end

   // Complete vector: shadow words 0..NW-2 plus the word generated this cycle.
   always_comb begin
      full_s                = shadow_r;
      full_s[SH_W-1 -: 32]  = lcg_word_s;
      vec_cnt_inc_s         = vec_cnt_r + 32'd1;
   end

   // Bits above IN_W in the top word and the shadow's top slot are never used.
   assign unused_s = ^{full_s, shadow_r[SH_W-1 -: 32]};

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         drst_cnt_r   <= 32'd0;
         widx_r       <= '0;
         shadow_r     <= '0;
         cycles_r     <= 32'd0;
         vec_cnt_r    <= 32'd0;
         stim_r       <= '0;
         stim_valid_r <= 1'b0;
         dut_rst_n_r  <= 1'b0;
         busy_r       <= 1'b0;
         done_r       <= 1'b0;
      end else if (bus.stall) begin
         // Everything holds; only the valid pulse is withdrawn.
         stim_valid_r <= 1'b0;
      end else begin
         stim_valid_r <= 1'b0;
         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  cycles_r    <= bus.cycles;
                  vec_cnt_r   <= 32'd0;
                  dut_rst_n_r <= 1'b0;
                  drst_cnt_r  <= 32'd0;
                  widx_r      <= '0;
                  state_r     <= ST_DRST;
                  busy_r      <= 1'b1;
                  done_r      <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            ST_DRST: begin
               if (drst_cnt_r == DRST_LAST) begin
                  state_r     <= ST_FILL;
                  dut_rst_n_r <= 1'b1;
                  drst_cnt_r  <= 32'd0;
               end else begin
                  drst_cnt_r <= drst_cnt_r + 32'd1;
               end
            end
            ST_FILL: begin
               for (int k = 0; k < NW; k++) begin
                  if (widx_r == IDX_W'(k)) begin
                     shadow_r[k*32 +: 32] <= lcg_word_s;
                  end
               end
               if (widx_r == LAST_IDX) begin
                  stim_r       <= full_s[IN_W-1:0];
                  stim_valid_r <= 1'b1;
                  vec_cnt_r    <= vec_cnt_inc_s;
                  widx_r       <= '0;
                  // 32-bit compare so cycles = all-ones ends when vec_cnt wraps to 0.
                  if (vec_cnt_inc_s == cycles_r + 32'd1) begin
                     state_r <= ST_DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_FILL;
                  end
               end else begin
                  widx_r <= widx_r + IDX_W'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dut_rst_n  = dut_rst_n_r;
   assign bus.stim       = stim_r;
   assign bus.stim_valid = stim_valid_r;
   assign bus.vec_cnt    = vec_cnt_r;
   assign bus.busy       = busy_r;
   assign bus.done       = done_r;

endmodule

// File: tb/tb_fuzz_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fuzz_seq_ctrl
// Scoreboard bench: each run's expected vectors come from a plain LCG model
// and are queued at start; a negedge monitor pops and compares on stim_valid.
// ----------------------------------------------------------------------------
module tb_fuzz_seq_ctrl;

   localparam int IN_W        = 258;
   localparam int DUT_RST_CYC = 2;
   localparam int NW          = 9;

   typedef struct {
      logic [IN_W-1:0] stim;
      logic [31:0]     cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fuzz_seq_ctrl_if #(.IN_W(IN_W)) bus ();

   fuzz_seq_ctrl #(.IN_W(IN_W), .DUT_RST_CYC(DUT_RST_CYC)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t            exp_q[$];
   int              valid_cyc_q[$];
   int              checks = 0;
   int              fails  = 0;
   int              cyc    = 0;
   int              start_cyc = 0;
   int              run_vcnt  = 0;
   logic [IN_W-1:0] last_stim = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [IN_W-1:0] act, input logic [IN_W-1:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Reference: one vector = NW consecutive LCG outputs, word k at bits [32k+31:32k].
   function automatic logic [IN_W-1:0] next_vec(inout logic [31:0] st);
      logic [NW*32-1:0] w;
      for (int k = 0; k < NW; k++) begin
         st = st * 32'h41C64E6D + 32'h00003039;
         w[k*32 +: 32] = st;
      end
      return w[IN_W-1:0];
   endfunction

   // Monitor / scoreboard.
   always @(negedge clk) begin : mon
      exp_t e;
      if (bus.stim_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_vector: got stim_valid=1 required no vector pending");
         end else begin
            e = exp_q.pop_front();
            check("stim", bus.stim, e.stim);
            check("vec_cnt", IN_W'(bus.vec_cnt), IN_W'(e.cnt));
         end
         run_vcnt++;
         last_stim = bus.stim;
         valid_cyc_q.push_back(cyc);
      end
   end

   task automatic issue(input logic [31:0] sd, input logic [31:0] cy);
      logic [31:0] st;
      exp_t e;
      st = sd;
      for (int j = 1; j <= int'(cy) + 1; j++) begin
         e.stim = next_vec(st);
         e.cnt  = 32'(j);
         exp_q.push_back(e);
      end
      run_vcnt = 0;
      valid_cyc_q.delete();
      @(posedge clk); #1;
      bus.stall  = 1'b0;
      bus.seed   = sd;
      bus.cycles = cy;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      start_cyc  = cyc;
   endtask

   task automatic count_drst(output int n);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.dut_rst_n === 1'b0) n++;
         else break;
      end
   endtask

   // Wait for done (bounded, optionally with random stall / ignored starts), then close the run.
   task automatic finish_run(input string name, input int vecs, input bit rnd);
      int t = 0;
      while (bus.done !== 1'b1 && t < 3000) begin
         @(posedge clk); #1;
         if (rnd) begin
            bus.stall = ($urandom_range(0, 2) == 0);
            bus.start = (bus.busy === 1'b1) && ($urandom_range(0, 7) == 0);
         end
         t++;
      end
      bus.stall = 1'b0;
      bus.start = 1'b0;
      check({name, "_done"}, IN_W'(bus.done), IN_W'(1'b1));
      @(negedge clk); #1;
      check({name, "_busy"}, IN_W'(bus.busy), IN_W'(1'b0));
      check({name, "_vectors"}, IN_W'(run_vcnt), IN_W'(vecs));
      check({name, "_final_vec_cnt"}, IN_W'(bus.vec_cnt), IN_W'(vecs));
      check({name, "_queue_left"}, IN_W'(exp_q.size()), IN_W'(0));
   endtask

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: got no end of test required finish before 2ms");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int n;
      logic [31:0] sd;
      logic [31:0] st;

      rst = 1'b1;
      bus.start = 1'b0; bus.stall = 1'b0; bus.seed = 32'd0; bus.cycles = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dut_rst_n",  IN_W'(bus.dut_rst_n),  IN_W'(1'b0));
      check("rst_stim",       bus.stim,              '0);
      check("rst_stim_valid", IN_W'(bus.stim_valid), IN_W'(1'b0));
      check("rst_vec_cnt",    IN_W'(bus.vec_cnt),    IN_W'(0));
      check("rst_busy",       IN_W'(bus.busy),       IN_W'(1'b0));
      check("rst_done",       IN_W'(bus.done),       IN_W'(1'b0));
      rst = 1'b0;

      // seed 0, one vector: LCG outputs 0x3039 then 0xD3DC167E.
      issue(32'd0, 32'd0);
      check("a_busy_after_start", IN_W'(bus.busy), IN_W'(1'b1));
      count_drst(n);
      check("a_drst_cycles", IN_W'(n), IN_W'(DUT_RST_CYC));
      finish_run("a", 1, 1'b0);
      check("a_word0", IN_W'(last_stim[31:0]),  IN_W'(32'h00003039));
      check("a_word1", IN_W'(last_stim[63:32]), IN_W'(32'hD3DC167E));
      check("a_latency", IN_W'(valid_cyc_q[0] - start_cyc), IN_W'(DUT_RST_CYC + NW));

      // Two vectors, started from DONE.
      issue(32'd0, 32'd1);
      count_drst(n);
      check("b_drst_cycles", IN_W'(n), IN_W'(DUT_RST_CYC));
      finish_run("b", 2, 1'b0);

      // Long-width run with cadence and top-word truncation checks.
      sd = 32'd1948728483;
      issue(sd, 32'd5);
      finish_run("c", 6, 1'b0);
      for (int i = 1; i < valid_cyc_q.size(); i++)
         check("c_cadence", IN_W'(valid_cyc_q[i] - valid_cyc_q[i-1]), IN_W'(NW));
      st = sd;
      repeat (6 * NW) st = st * 32'h41C64E6D + 32'h00003039;
      check("c_top_bits", IN_W'(last_stim[257:256]), IN_W'(st[1:0]));

      // Three-cycle stall in the middle of the first FILL.
      issue($urandom, 32'd1);
      repeat (6) @(posedge clk);
      #1;
      bus.stall = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("d_no_valid_in_stall", IN_W'(bus.stim_valid), IN_W'(1'b0));
         @(posedge clk); #1;
      end
      bus.stall = 1'b0;
      finish_run("d", 2, 1'b0);
      check("d_latency", IN_W'(valid_cyc_q[0] - start_cyc), IN_W'(DUT_RST_CYC + NW + 3));
      check("d_cadence", IN_W'(valid_cyc_q[1] - valid_cyc_q[0]), IN_W'(NW));

      // Reset mid-FILL (with stall high), then same seed again.
      sd = $urandom;
      issue(sd, 32'd1);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      bus.stall = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.stall = 1'b0;
      exp_q.delete();
      check("e_rst_busy",      IN_W'(bus.busy),      IN_W'(1'b0));
      check("e_rst_dut_rst_n", IN_W'(bus.dut_rst_n), IN_W'(1'b0));
      check("e_rst_vec_cnt",   IN_W'(bus.vec_cnt),   IN_W'(0));
      check("e_rst_stim",      bus.stim,             '0);
      issue(sd, 32'd1);
      finish_run("e", 2, 1'b0);

      // start during FILL must be ignored.
      sd = $urandom;
      issue(sd, 32'd2);
      repeat (5) @(posedge clk);
      #1;
      bus.seed   = ~sd;
      bus.cycles = 32'd7;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start  = 1'b0;
      finish_run("f", 3, 1'b0);

      // Randomized runs with random stall and ignored starts.
      for (int r = 0; r < 5; r++) begin
         n = $urandom_range(0, 3);
         issue($urandom, 32'(n));
         finish_run("g", n + 1, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/fuzz_seq_ctrl.md
FUZZ_SEQ_CTRL -- requirements
Module: fuzz_seq_ctrl

Interface
REQ-001 SHALL have parameter IN_W, default 258: width of the stimulus vector driven to the DUT.
REQ-002 SHALL have parameter DUT_RST_CYC, default 2: cycles for which dut_rst_n is held low per run.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-007 seed  in  32  LCG seed, captured on an accepted start.
REQ-008 cycles  in  32  run length, captured on an accepted start; run produces cycles+1 vectors.
REQ-009 stall  in  1  when high, FSM, LCG and counters hold their values.
REQ-010 dut_rst_n  out  1  active-low reset to the DUT.
REQ-011 stim  out  IN_W  current stimulus vector to the DUT.
REQ-012 stim_valid  out  1  one-cycle pulse when stim takes a new vector.
REQ-013 vec_cnt  out  32  vectors issued in the current run.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 done  out  1  high while in DONE.

Function
REQ-016 SHALL use LCG next = state*32'h41C64E6D + 32'h3039 mod 2^32, one step per generated word.
REQ-017 SHALL use NW = ceil(IN_W/32); word k fills stim bits [32k+31:32k]; the top word contributes only its low IN_W-32*(NW-1) bits.
REQ-018 SHALL implement states IDLE, DRST, FILL, DONE.
REQ-019 IDLE: on start, load LCG with seed, latch cycles, clear vec_cnt, drive dut_rst_n low, go to DRST.
REQ-020 DRST: hold dut_rst_n low for exactly DUT_RST_CYC cycles, then go to FILL; generation does not run in DRST.
REQ-021 FILL: generate one word per cycle into a shadow register, words 0..NW-1 in order.
REQ-022 On the cycle word NW-1 is generated, SHALL load the full shadow into stim (registered, visible the next cycle), pulse stim_valid and increment vec_cnt.
REQ-023 After the vector at which vec_cnt reaches cycles+1, SHALL go to DONE; otherwise restart FILL at word 0 with no idle cycle.
REQ-024 Vector cadence SHALL be exactly NW cycles when stall is low.
REQ-025 DONE: hold stim, keep dut_rst_n high, and return to IDLE on the next start, which also begins a new run from IDLE semantics.
REQ-026 start outside IDLE and DONE SHALL be ignored.
REQ-027 stall SHALL freeze everything, including the DRST count and word index, with no skipped or duplicated word.
REQ-028 stim_valid SHALL not pulse while stall is high.
REQ-029 cycles=0 SHALL produce exactly one vector.
REQ-030 cycles=32'hFFFFFFFF: vec_cnt SHALL wrap to 0 after the final vector and the FSM SHALL still reach DONE.

Reset
REQ-031 rst SHALL force state IDLE, dut_rst_n=0, stim=0, stim_valid=0, vec_cnt=0, busy=0, done=0, LCG state=0, word index=0.
REQ-032 rst asserted mid-run SHALL abort the run and discard the partial shadow; stall SHALL have no effect during rst.

Structure
REQ-033 Package fuzz_seq_pkg SHALL hold the LCG multiplier and increment constants and the state enum type.
REQ-034 The LCG SHALL be a sub-module fuzz_lcg32 with ports clk, rst, load, seed, step, and value.

Verification
REQ-035 seed=0, cycles=0, IN_W=32, start -> dut_rst_n low for 2 cycles, then one stim_valid with stim=32'h00003039, then done=1.
REQ-036 seed=0, cycles=1, IN_W=32 -> second vector stim=32'hD3DC167E, vec_cnt=2, done=1.
REQ-037 IN_W=258, seed=1948728483, cycles=5 -> 6 vectors, stim_valid every 9 cycles, every bit matches a software LCG model using the same word order, and stim[257:256] equals the low 2 bits of word 8.
REQ-038 stall held 3 cycles mid-FILL -> stim sequence identical to the no-stall run, and the vector arrives 3 cycles later.
REQ-039 rst pulsed mid-FILL, then a new start with the same seed -> output identical to a fresh run, with no leftover shadow bits.
REQ-040 start pulsed during FILL -> ignored, with run length and stim values unchanged.
